// File: rtl/fm_demod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_demod_pkg
// Description : Shared definitions for the FM demodulator front end:
//               byte-merge state encoding, sample width and the log2 size
//               of the 128-sample averaging window.
// Revision    : 1.0 - initial release
// ============================================================================
package fm_demod_pkg;

    // Width of one assembled demodulator sample (two bytes).
    localparam int SAMPLE_W    = 16;

    // Width of one byte from the front end.
    localparam int BYTE_W      = 8;

    // log2 of the averaging window; the sample index wraps on this.
    localparam int WINDOW_LOG2 = 7;

    // Byte-merge controller states.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_FIRST  = 2'd1,
        ST_WAIT_SECOND = 2'd2
    } merge_state_e;

endpackage : fm_demod_pkg
`default_nettype wire

// File: rtl/sample_merge.sv
`default_nettype none
// ============================================================================
// Module      : sample_merge
// Description : Assembles pairs of bytes from the byte-wide front end into
//               one signed 16-bit sample, presents it with a one-cycle
//               merge_finished_o strobe and tracks a mod-128 sample index
//               aligned to the averaging window.
//
// Ports       : clk              - system clock
//               rst              - synchronous active-high reset
//               start_i          - enable; low idles and drops partial byte
//               byte_valid_i     - byte_i qualifier (no backpressure)
//               byte_i[7:0]      - input byte
//               data_o[WIDTH-1:0]- last assembled sample, held between strobes
//               merge_finished_o - one-cycle pulse marking a new data_o
//               sample_cnt_o[6:0]- index of the sample on data_o, mod 128
//               err_o            - sticky timeout flag
//
// Options     : MERGE_TIMEOUT_EN - when defined, a partial sample is dropped
//               and err_o set if TIMEOUT cycles pass in WAIT_SECOND without a
//               byte. When undefined, WAIT_SECOND waits forever and err_o=0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sample_merge
    import fm_demod_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 1,
    parameter int TIMEOUT   = 255
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   start_i,
    input  wire logic                   byte_valid_i,
    input  wire logic [BYTE_W-1:0]      byte_i,
    output logic      [WIDTH-1:0]       data_o,
    output logic                        merge_finished_o,
    output logic      [WINDOW_LOG2-1:0] sample_cnt_o,
    output logic                        err_o
);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if (WIDTH != SAMPLE_W) begin : g_bad_width
        $error("sample_merge: WIDTH must be %0d", SAMPLE_W);
    end

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sample_merge: TIMEOUT must be at least 1");
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    merge_state_e               state_q,  state_d;
    logic [BYTE_W-1:0]          hold_q,   hold_d;
    logic [WIDTH-1:0]           data_q,   data_d;
    logic                       strobe_q, strobe_d;
    logic [WINDOW_LOG2-1:0]     cnt_q,    cnt_d;

    // Sample formed from the held first byte and the current byte.
    logic [WIDTH-1:0]           w_sample;

    assign w_sample = (LSB_FIRST != 0) ? {byte_i, hold_q} : {hold_q, byte_i};

`ifdef MERGE_TIMEOUT_EN
    // Counter is at least 8 bits, wider only if TIMEOUT needs it.
    localparam int C_TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Timeout fires on the idle cycle that would make the count reach TIMEOUT.
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT - 1);

    logic [C_TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic                       err_q,    err_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
`ifdef MERGE_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
`endif

        if (!start_i) begin
            // Disable wins over everything, including a second byte arriving
            // this cycle: the partial sample is dropped, outputs are held.
            state_d  = ST_IDLE;
            hold_d   = '0;
`ifdef MERGE_TIMEOUT_EN
            to_cnt_d = '0;
            err_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Bytes are never taken on the enabling cycle.
                    state_d = ST_WAIT_FIRST;
                end

                ST_WAIT_FIRST: begin
                    if (byte_valid_i) begin
                        hold_d  = byte_i;
                        state_d = ST_WAIT_SECOND;
`ifdef MERGE_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end

                ST_WAIT_SECOND: begin
                    if (byte_valid_i) begin
                        data_d   = w_sample;
                        strobe_d = 1'b1;
                        cnt_d    = cnt_q + WINDOW_LOG2'(1);
                        state_d  = ST_WAIT_FIRST;
`ifdef MERGE_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
`ifdef MERGE_TIMEOUT_EN
                    else if (to_cnt_q == C_TO_LAST) begin
                        hold_d   = '0;
                        err_d    = 1'b1;
                        to_cnt_d = '0;
                        state_d  = ST_WAIT_FIRST;
                    end else begin
                        to_cnt_d = to_cnt_q + C_TO_W'(1);
                    end
`endif
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef MERGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign data_o           = data_q;
    assign merge_finished_o = strobe_q;
    assign sample_cnt_o     = cnt_q;

endmodule : sample_merge
`default_nettype wire

// File: tb/tb_sample_merge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_merge
// Description : Self-checking bench for sample_merge. Two instances share one
//               stimulus stream, one LSB-first and one MSB-first. A table of
//               hand-derived vectors, directed corner sequences and a random
//               phase are all checked against a queue-based reference model.
//               Timeout checks are present when MERGE_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_merge;

    localparam int C_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;

    logic [15:0] data_l,   data_m;
    logic        fin_l,    fin_m;
    logic [6:0]  cnt_l,    cnt_m;
    logic        err_l,    err_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sample_merge #(.WIDTH(16), .LSB_FIRST(1), .TIMEOUT(C_TO)) dut_lsb (
        .clk(clk), .rst(rst), .start_i(start_i), .byte_valid_i(byte_valid_i),
        .byte_i(byte_i), .data_o(data_l), .merge_finished_o(fin_l),
        .sample_cnt_o(cnt_l), .err_o(err_l)
    );

    sample_merge #(.WIDTH(16), .LSB_FIRST(0), .TIMEOUT(C_TO)) dut_msb (
        .clk(clk), .rst(rst), .start_i(start_i), .byte_valid_i(byte_valid_i),
        .byte_i(byte_i), .data_o(data_m), .merge_finished_o(fin_m),
        .sample_cnt_o(cnt_m), .err_o(err_m)
    );

    // ------------------------------------------------------------------------
    // Reference model: enable flag, a queue holding at most one pending byte,
    // an idle-cycle count and the last published outputs.
    // ------------------------------------------------------------------------
    logic        m_active;
    logic [7:0]  m_pend[$];
    int          m_idle;
    logic [15:0] m_lsb, m_msb;
    logic        m_fin;
    int          m_cnt;
    logic        m_err;

    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic [7:0] b);
        logic [7:0] first;
        m_fin = 1'b0;
        if (r) begin
            m_active = 1'b0; m_pend.delete(); m_idle = 0;
            m_lsb = 16'h0; m_msb = 16'h0; m_cnt = 0; m_err = 1'b0;
        end else if (!s) begin
            m_active = 1'b0; m_pend.delete(); m_idle = 0; m_err = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (v) begin
            m_idle = 0;
            if (m_pend.size() == 0) begin
                m_pend.push_back(b);
            end else begin
                first = m_pend.pop_front();
                m_lsb = {b, first};
                m_msb = {first, b};
                m_fin = 1'b1;
                m_cnt = (m_cnt + 1) % 128;
            end
        end else if (m_pend.size() != 0) begin
`ifdef MERGE_TIMEOUT_EN
            m_idle++;
            if (m_idle == C_TO) begin
                m_pend.delete();
                m_idle = 0;
                m_err  = 1'b1;
            end
`endif
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("lsb.data", 32'(data_l), 32'(m_lsb));
        chk("msb.data", 32'(data_m), 32'(m_msb));
        chk("lsb.fin",  32'(fin_l),  32'(m_fin));
        chk("msb.fin",  32'(fin_m),  32'(m_fin));
        chk("lsb.cnt",  32'(cnt_l),  32'(m_cnt));
        chk("msb.cnt",  32'(cnt_m),  32'(m_cnt));
        chk("lsb.err",  32'(err_l),  32'(m_err));
        chk("msb.err",  32'(err_m),  32'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check after.
    task automatic cycle(input logic r, input logic s, input logic v,
                         input logic [7:0] b);
        rst = r; start_i = s; byte_valid_i = v; byte_i = b;
        @(posedge clk);
        model_step(r, s, v, b);
        #1;
        chk_model();
    endtask

    // ------------------------------------------------------------------------
    // Hand-derived vectors: inputs for one cycle and outputs after its edge.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        r, s, v;
        logic [7:0]  b;
        logic [15:0] lsb, msb;
        logic        fin;
        logic [6:0]  cnt;
    } vec_t;

    localparam int C_NVEC = 23;
    vec_t tbl [C_NVEC];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int strobes;
        int last_edge;
        int edge_no;

        rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
        model_step(1'b1, 1'b0, 1'b0, 8'h00);

        //          r     s     v     byte    lsb       msb       fin   cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 7'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h99, 16'h0000, 16'h0000, 1'b0, 7'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h34, 16'h0000, 16'h0000, 1'b0, 7'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h12, 16'h1234, 16'h3412, 1'b1, 7'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h1234, 16'h3412, 1'b0, 7'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 16'h1234, 16'h3412, 1'b0, 7'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h80, 16'h80FF, 16'hFF80, 1'b1, 7'd2};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h77, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h77, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h01, 16'h80FF, 16'hFF80, 1'b0, 7'd2};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h02, 16'h0201, 16'h0102, 1'b1, 7'd3};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h44, 16'h0201, 16'h0102, 1'b0, 7'd3};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h55, 16'h0201, 16'h0102, 1'b0, 7'd3};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0201, 16'h0102, 1'b0, 7'd3};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 8'h66, 16'h0201, 16'h0102, 1'b0, 7'd3};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 7'd0};
        tbl[20] = '{1'b0, 1'b1, 1'b1, 8'h11, 16'h0000, 16'h0000, 1'b0, 7'd0};
        tbl[21] = '{1'b0, 1'b1, 1'b1, 8'h22, 16'h0000, 16'h0000, 1'b0, 7'd0};
        tbl[22] = '{1'b0, 1'b1, 1'b1, 8'h33, 16'h3322, 16'h2233, 1'b1, 7'd1};

        for (int i = 0; i < C_NVEC; i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].b);
            chk($sformatf("tbl%0d.lsb", i), 32'(data_l), 32'(tbl[i].lsb));
            chk($sformatf("tbl%0d.msb", i), 32'(data_m), 32'(tbl[i].msb));
            chk($sformatf("tbl%0d.fin", i), 32'(fin_l),  32'(tbl[i].fin));
            chk($sformatf("tbl%0d.cnt", i), 32'(cnt_l),  32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.err", i), 32'(err_l),  32'd0);
        end

        // 256 back-to-back bytes: 128 strobes two cycles apart, index wraps.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        strobes   = 0;
        last_edge = -1;
        for (int i = 0; i < 256; i++) begin
            edge_no = i;
            cycle(1'b0, 1'b1, 1'b1, 8'(i * 7 + 3));
            if (fin_l) begin
                if (last_edge >= 0)
                    chk("b2b.gap", 32'(edge_no - last_edge), 32'd2);
                last_edge = edge_no;
                strobes++;
            end
        end
        chk("b2b.strobes", 32'(strobes), 32'd128);
        chk("b2b.wrap",    32'(cnt_l),   32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("b2b.single",  32'(fin_l),   32'd0);

        // Reset in WAIT_SECOND: outputs return to reset values, no strobe.
        cycle(1'b0, 1'b1, 1'b1, 8'h5A);
        cycle(1'b1, 1'b1, 1'b1, 8'hA5);
        chk("rst2.data", 32'(data_l), 32'd0);
        chk("rst2.fin",  32'(fin_l),  32'd0);
        chk("rst2.cnt",  32'(cnt_l),  32'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'hC3);
        chk("rst2.nofin", 32'(fin_l), 32'd0);

`ifdef MERGE_TIMEOUT_EN
        // Byte 0x55, four idle cycles, then 0x10, 0x20.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("to.err_early", 32'(err_l), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("to.err_set",   32'(err_l), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 8'h10);
        cycle(1'b0, 1'b1, 1'b1, 8'h20);
        chk("to.data", 32'(data_l), 32'h2010);
        chk("to.fin",  32'(fin_l),  32'd1);
        chk("to.sticky", 32'(err_l), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("to.err_clr", 32'(err_l), 32'd0);
`endif

        // Random phase against the model.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 19) != 0),
                  ($urandom_range(0, 9) < 6),
                  8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sample_merge
`default_nettype wire
